// File: rtl/trig_pkg.sv
// trig_pkg: shared types and default sizes for the trojan sequence trigger
package trig_pkg;
  typedef enum logic {MODE_COUNT, MODE_SEQ} mode_e;
  typedef enum logic [1:0] {ST_IDLE, ST_TRACK, ST_FIRED} state_e;
  localparam int DEF_WIDTH = 128;
  localparam int DEF_NUM_PAT = 4;
endpackage

// File: rtl/pattern_match.sv
// pattern_match: masked equality compare; an all-zero mask never hits
module pattern_match #(
  parameter int WIDTH = 128
) (
  input  logic [WIDTH-1:0] state,
  input  logic [WIDTH-1:0] pat,
  input  logic [WIDTH-1:0] mask,
  output logic             hit
);
  assign hit = (|mask) && ~|((state ^ pat) & mask);
endmodule

// File: rtl/trojan_seq_trigger.sv
// trojan_seq_trigger: sticky trigger on a counted or ordered set of masked state patterns
module trojan_seq_trigger
  import trig_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_PAT = DEF_NUM_PAT,
  parameter int CNT_W   = 8,
  parameter int WIN_W   = 16,
  parameter int IDX_W   = $clog2(NUM_PAT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [WIDTH-1:0] cfg_pat,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic             cfg_mode,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic [WIN_W-1:0] cfg_window,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] state,
  input  logic             clr,
  output logic             tj_trig,
  output logic [CNT_W-1:0] match_cnt,
  output logic [IDX_W:0]   seq_pos
);
  logic [WIDTH-1:0] pat [NUM_PAT];
  logic [WIDTH-1:0] mask [NUM_PAT];
  logic [NUM_PAT-1:0] raw_hit, hit;
  state_e st, st_n;
  logic [CNT_W-1:0] cnt_n, cnt_inc, thr, len;
  logic [IDX_W:0] pos_n, pos_inc;
  logic [WIN_W-1:0] win, win_n, win_inc;
  logic seq, any_hit, exp_hit, timeout;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PAT; i++) begin
        pat[i] <= '0;
        mask[i] <= '0;
      end
    end else if (cfg_we && int'(cfg_idx) < NUM_PAT) begin
      pat[cfg_idx] <= cfg_pat;
      mask[cfg_idx] <= cfg_mask;
    end
  end
  for (genvar g = 0; g < NUM_PAT; g++) begin : g_match
    pattern_match #(.WIDTH(WIDTH)) u_match (
      .state(state),
      .pat(pat[g]),
      .mask(mask[g]),
      .hit(raw_hit[g])
    );
  end
  assign hit = raw_hit & {NUM_PAT{in_valid}};
  assign any_hit = |hit;
  assign seq = mode_e'(cfg_mode) == MODE_SEQ;
  assign thr = cfg_thresh == '0 ? CNT_W'(1) : cfg_thresh;
  assign len = cfg_thresh == '0 ? CNT_W'(1) :
               cfg_thresh > CNT_W'(NUM_PAT) ? CNT_W'(NUM_PAT) : cfg_thresh;
  assign cnt_inc = match_cnt == '1 ? match_cnt : match_cnt + CNT_W'(1);
  assign pos_inc = seq_pos + (IDX_W+1)'(1);
  assign win_inc = win + WIN_W'(1);
  assign timeout = cfg_window != '0 && win_inc >= cfg_window;
  always_comb begin
    exp_hit = 1'b0;
    for (int i = 0; i < NUM_PAT; i++)
      exp_hit = exp_hit | (hit[i] && seq_pos == (IDX_W+1)'(i));
  end
  // A timeout takes priority over an expected match landing on the same edge
  always_comb begin
    st_n = st;
    cnt_n = match_cnt;
    pos_n = seq_pos;
    win_n = win;
    if (clr) begin
      st_n = ST_IDLE;
      cnt_n = '0;
      pos_n = '0;
      win_n = '0;
    end else if (st != ST_FIRED) begin
      if (!seq) begin
        if (any_hit) begin
          cnt_n = cnt_inc;
          st_n = cnt_inc >= thr ? ST_FIRED : ST_TRACK;
        end
      end else if (st == ST_TRACK && timeout) begin
        st_n = ST_IDLE;
        pos_n = '0;
        win_n = '0;
      end else begin
        win_n = st == ST_TRACK ? win_inc : '0;
        if (exp_hit) begin
          pos_n = pos_inc;
          st_n = CNT_W'(pos_inc) >= len ? ST_FIRED : ST_TRACK;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= ST_IDLE;
      match_cnt <= '0;
      seq_pos <= '0;
      win <= '0;
    end else begin
      st <= st_n;
      match_cnt <= cnt_n;
      seq_pos <= pos_n;
      win <= win_n;
    end
  end
  assign tj_trig = st == ST_FIRED;
endmodule

// File: tb/tb_trojan_seq_trigger.sv
// tb_trojan_seq_trigger: directed scoreboard bench for the trojan sequence trigger
module tb_trojan_seq_trigger;
  import trig_pkg::*;
  localparam int W = 128, N = 4, CW = 8, WW = 16, IW = 2;
  localparam logic [W-1:0] P0 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [W-1:0] A = 128'hA5A5A5A5_00000001_11111111_22222222;
  localparam logic [W-1:0] B = 128'hB6B6B6B6_00000002_33333333_44444444;
  localparam logic [W-1:0] C = 128'hC7C7C7C7_00000003_55555555_66666666;
  localparam logic [W-1:0] D = 128'hD8D8D8D8_00000004_77777777_88888888;
  localparam logic [W-1:0] M = 128'h0badf00d_deadbeef_cafebabe_12345678;
  logic clk = 0, rst = 1, cfg_we = 0, cfg_mode = 0, in_valid = 0, clr = 0;
  logic [IW-1:0] cfg_idx = '0;
  logic [W-1:0] cfg_pat = '0, cfg_mask = '0, state = '0;
  logic [CW-1:0] cfg_thresh = '0;
  logic [WW-1:0] cfg_window = '0;
  logic tj_trig;
  logic [CW-1:0] match_cnt;
  logic [IW:0] seq_pos;
  int checks = 0, errors = 0;
  typedef struct {
    logic trig;
    logic [CW-1:0] cnt;
    logic [IW:0] pos;
  } exp_t;
  exp_t exp_q[$];
  always #5 clk = ~clk;
  trojan_seq_trigger #(.WIDTH(W), .NUM_PAT(N), .CNT_W(CW), .WIN_W(WW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pat(cfg_pat),
    .cfg_mask(cfg_mask), .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh),
    .cfg_window(cfg_window), .in_valid(in_valid), .state(state), .clr(clr),
    .tj_trig(tj_trig), .match_cnt(match_cnt), .seq_pos(seq_pos)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic cyc(input string tag, input logic v, input logic [W-1:0] d,
                     input logic t, input int c, input int p);
    exp_t e;
    in_valid = v;
    state = d;
    exp_q.push_back('{t, CW'(c), (IW+1)'(p)});
    tick;
    e = exp_q.pop_front();
    chk({tag, ".trig"}, 32'(tj_trig), 32'(e.trig));
    chk({tag, ".cnt"}, 32'(match_cnt), 32'(e.cnt));
    chk({tag, ".pos"}, 32'(seq_pos), 32'(e.pos));
    in_valid = 0;
  endtask
  task automatic wr(input int idx, input logic [W-1:0] p, input logic [W-1:0] m);
    cfg_we = 1;
    cfg_idx = IW'(idx);
    cfg_pat = p;
    cfg_mask = m;
    tick;
    cfg_we = 0;
  endtask
  task automatic do_clr(input logic mode, input int thr, input int win);
    cfg_mode = mode;
    cfg_thresh = CW'(thr);
    cfg_window = WW'(win);
    clr = 1;
    cyc("clr", 0, '0, 0, 0, 0);
    clr = 0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1;
    cyc("reset", 0, '0, 0, 0, 0);
    cyc("reset", 1, '0, 0, 0, 0);
    rst = 0;
    // COUNT mode, threshold 3
    do_clr(0, 3, 0);
    wr(0, P0, '1);
    cyc("cnt_m1", 1, P0, 0, 1, 0);
    cyc("cnt_miss", 1, P0 ^ 128'h1, 0, 1, 0);
    cyc("cnt_m2", 1, P0, 0, 2, 0);
    cyc("cnt_miss", 1, ~P0, 0, 2, 0);
    cyc("cnt_m3", 1, P0, 1, 3, 0);
    for (int i = 0; i < 20; i++) cyc("cnt_hold", 1, P0, 1, 3, 0);
    do_clr(0, 3, 0);
    cyc("cfg_kept", 1, P0, 0, 1, 0);
    // SEQ ordering with gaps and out-of-order entries
    do_clr(1, 3, 0);
    wr(0, A, '1);
    wr(1, B, '1);
    wr(2, C, '1);
    cyc("seq_b", 1, B, 0, 0, 0);
    cyc("seq_a", 1, A, 0, 0, 1);
    cyc("seq_c", 1, C, 0, 0, 1);
    cyc("seq_b2", 1, B, 0, 0, 2);
    cyc("seq_c2", 1, C, 1, 0, 3);
    cyc("seq_hold", 1, A, 1, 0, 3);
    // window timeout: the edge that expires the window drops a coincident match
    do_clr(1, 2, 5);
    cyc("win_a", 1, A, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc("win_wait", 0, '0, 0, 0, 1);
    cyc("win_b5", 1, B, 0, 0, 0);
    cyc("win_b6", 1, B, 0, 0, 0);
    cyc("win_a2", 1, A, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc("win_wait2", 0, '0, 0, 0, 1);
    cyc("win_b4", 1, B, 1, 0, 2);
    // masking and disabled entries
    do_clr(0, 255, 0);
    wr(1, M, {{120{1'b1}}, 8'h00});
    cyc("mask_low", 1, M ^ 128'h5a, 0, 1, 0);
    cyc("mask_b8", 1, M ^ 128'h100, 0, 1, 0);
    wr(0, A, '0);
    wr(1, M, '0);
    wr(2, C, '0);
    cyc("dis_exact", 1, A, 0, 1, 0);
    cyc("dis_zero", 1, '0, 0, 1, 0);
    for (int i = 0; i < 1000; i++)
      cyc("dis_rand", 1, {$urandom, $urandom, $urandom, $urandom}, 0, 1, 0);
    // clr precedence and zero threshold treated as one
    do_clr(0, 0, 0);
    wr(0, P0, '1);
    clr = 1;
    cyc("clr_vs_hit", 1, P0, 0, 0, 0);
    clr = 0;
    cyc("thr0", 1, P0, 1, 1, 0);
    clr = 1;
    cyc("clr_fired", 0, '0, 0, 0, 0);
    clr = 0;
    // reset mid-track wipes the table
    do_clr(1, 3, 0);
    wr(0, A, '1);
    wr(1, B, '1);
    wr(2, C, '1);
    cyc("rt_a", 1, A, 0, 0, 1);
    cyc("rt_b", 1, B, 0, 0, 2);
    rst = 1;
    cyc("rt_rst", 1, C, 0, 0, 0);
    rst = 0;
    cyc("rt_resend", 1, A, 0, 0, 0);
    cyc("rt_zero", 1, '0, 0, 0, 0);
    // length above NUM_PAT clamps to NUM_PAT
    do_clr(1, 200, 0);
    wr(0, A, '1);
    wr(1, B, '1);
    wr(2, C, '1);
    wr(3, D, '1);
    cyc("cl_a", 1, A, 0, 0, 1);
    cyc("cl_b", 1, B, 0, 0, 2);
    cyc("cl_c", 1, C, 0, 0, 3);
    cyc("cl_d", 1, D, 1, 0, 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
